// File: rtl/hazard_tracker_pkg.sv
// Shared encodings, stage record and defaults for the D-stage hazard tracker.
package hazard_tracker_pkg;

  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_M    = 2'd2;
  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;
  localparam int unsigned MD_CNT_W        = 8;

  typedef struct packed {
    logic       reg_write;
    logic [4:0] a3;
    logic [1:0] tnew;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  // A producer blocks a consumer only if its value is still further away than the use point.
  function automatic logic gpr_hazard(stage_t st, logic [4:0] src, logic used, logic [1:0] tuse);
    return used && st.reg_write && (st.a3 == src) && (src != 5'd0) && (st.tnew > tuse);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide busy counter: loads a cycle count on start, counts down to zero.
module md_busy_counter
  import hazard_tracker_pkg::*;
#(
  parameter int unsigned W = MD_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_tracker.sv
// Shadow E/M/W destination pipeline plus Tuse/Tnew and HI/LO busy stall generation.
module hazard_tracker
  import hazard_tracker_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic       D_use_rs,
  input  logic       D_use_rt,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic       D_RegWrite,
  input  logic [4:0] D_RegA3,
  input  logic [1:0] D_Tnew,
  input  logic       D_md_start,
  input  logic       D_md_div,
  input  logic       D_uses_md,
  output logic       stall,
  output logic       E_RegWrite,
  output logic       M_RegWrite,
  output logic       W_RegWrite,
  output logic [4:0] E_RegA3,
  output logic [4:0] M_RegA3,
  output logic [4:0] W_RegA3,
  output logic [1:0] E_Tnew,
  output logic [1:0] M_Tnew,
  output logic       md_busy
);

  stage_t       d_rec;
  stage_t       e_q, e_d;
  stage_t       m_q, m_d;
  logic         w_rw_q, w_rw_d;
  logic [4:0]   w_a3_q, w_a3_d;
  logic         gpr_stall;
  logic         md_stall;
  logic         md_load;
  logic [MD_CNT_W-1:0] md_load_val;

  always_comb begin
    d_rec.reg_write = D_RegWrite && (D_RegA3 != 5'd0);
    d_rec.a3        = D_RegA3;
    d_rec.tnew      = D_Tnew;

    gpr_stall = gpr_hazard(e_q, D_rs, D_use_rs, D_Tuse_rs)
              | gpr_hazard(e_q, D_rt, D_use_rt, D_Tuse_rt)
              | gpr_hazard(m_q, D_rs, D_use_rs, D_Tuse_rs)
              | gpr_hazard(m_q, D_rt, D_use_rt, D_Tuse_rt);
    md_stall  = D_uses_md && md_busy;
    stall     = gpr_stall | md_stall;

    // On a stall only E takes a bubble; M and W keep draining.
    e_d      = stall ? STAGE_BUBBLE : d_rec;
    m_d      = e_q;
    m_d.tnew = (e_q.tnew != 2'd0) ? (e_q.tnew - 2'd1) : 2'd0;
    w_rw_d   = m_q.reg_write;
    w_a3_d   = m_q.a3;

    md_load     = D_md_start && !stall;
    md_load_val = D_md_div ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q    <= STAGE_BUBBLE;
      m_q    <= STAGE_BUBBLE;
      w_rw_q <= 1'b0;
      w_a3_q <= '0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_rw_q <= w_rw_d;
      w_a3_q <= w_a3_d;
    end
  end

  md_busy_counter #(
    .W(MD_CNT_W)
  ) u_md_busy_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (md_load),
    .load_val (md_load_val),
    .busy     (md_busy)
  );

  assign E_RegWrite = e_q.reg_write;
  assign E_RegA3    = e_q.a3;
  assign E_Tnew     = e_q.tnew;
  assign M_RegWrite = m_q.reg_write;
  assign M_RegA3    = m_q.a3;
  assign M_Tnew     = m_q.tnew;
  assign W_RegWrite = w_rw_q;
  assign W_RegA3    = w_a3_q;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed scoreboard bench for hazard_tracker: expectations are queued per step and checked mid-cycle.
module tb_hazard_tracker;

  typedef enum int unsigned {
    S_STALL, S_BUSY, S_ERW, S_EA3, S_ETN, S_MRW, S_MA3, S_MTN, S_WRW, S_WA3
  } sig_e;

  typedef struct {
    string       tag;
    sig_e        sel;
    logic [7:0]  val;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_RegA3;
  logic       D_use_rs, D_use_rt, D_RegWrite, D_md_start, D_md_div, D_uses_md;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
  logic       stall, E_RegWrite, M_RegWrite, W_RegWrite, md_busy;
  logic [4:0] E_RegA3, M_RegA3, W_RegA3;
  logic [1:0] E_Tnew, M_Tnew;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  hazard_tracker #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_use_rs   (D_use_rs),
    .D_use_rt   (D_use_rt),
    .D_Tuse_rs  (D_Tuse_rs),
    .D_Tuse_rt  (D_Tuse_rt),
    .D_RegWrite (D_RegWrite),
    .D_RegA3    (D_RegA3),
    .D_Tnew     (D_Tnew),
    .D_md_start (D_md_start),
    .D_md_div   (D_md_div),
    .D_uses_md  (D_uses_md),
    .stall      (stall),
    .E_RegWrite (E_RegWrite),
    .M_RegWrite (M_RegWrite),
    .W_RegWrite (W_RegWrite),
    .E_RegA3    (E_RegA3),
    .M_RegA3    (M_RegA3),
    .W_RegA3    (W_RegA3),
    .E_Tnew     (E_Tnew),
    .M_Tnew     (M_Tnew),
    .md_busy    (md_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] observe(sig_e s);
    case (s)
      S_STALL: return {7'd0, stall};
      S_BUSY:  return {7'd0, md_busy};
      S_ERW:   return {7'd0, E_RegWrite};
      S_EA3:   return {3'd0, E_RegA3};
      S_ETN:   return {6'd0, E_Tnew};
      S_MRW:   return {7'd0, M_RegWrite};
      S_MA3:   return {3'd0, M_RegA3};
      S_MTN:   return {6'd0, M_Tnew};
      S_WRW:   return {7'd0, W_RegWrite};
      default: return {3'd0, W_RegA3};
    endcase
  endfunction

  task automatic expect_sig(input string tag, input sig_e sel, input int v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = 8'(v);
    sb.push_back(e);
  endtask

  task automatic expect_idle(input string tag);
    expect_sig({tag, ".stall"}, S_STALL, 0);
    expect_sig({tag, ".busy"},  S_BUSY,  0);
    expect_sig({tag, ".erw"},   S_ERW,   0);
    expect_sig({tag, ".ea3"},   S_EA3,   0);
    expect_sig({tag, ".etn"},   S_ETN,   0);
    expect_sig({tag, ".mrw"},   S_MRW,   0);
    expect_sig({tag, ".ma3"},   S_MA3,   0);
    expect_sig({tag, ".mtn"},   S_MTN,   0);
    expect_sig({tag, ".wrw"},   S_WRW,   0);
    expect_sig({tag, ".wa3"},   S_WA3,   0);
  endtask

  task automatic check_now();
    exp_t       e;
    logic [7:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      total++;
      assert (o === e.val) else begin
        bad++;
        $error("FAIL %s: observed=%0d expected=%0d", e.tag, o, e.val);
      end
    end
  endtask

  task automatic drive(input int rs, input int urs, input int trs,
                       input int rt, input int urt, input int trt,
                       input int rw, input int a3, input int tnew,
                       input int mds, input int mdd, input int umd);
    D_rs       = 5'(rs);
    D_use_rs   = 1'(urs);
    D_Tuse_rs  = 2'(trs);
    D_rt       = 5'(rt);
    D_use_rt   = 1'(urt);
    D_Tuse_rt  = 2'(trt);
    D_RegWrite = 1'(rw);
    D_RegA3    = 5'(a3);
    D_Tnew     = 2'(tnew);
    D_md_start = 1'(mds);
    D_md_div   = 1'(mdd);
    D_uses_md  = 1'(umd);
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called 1 time unit after a rising edge; checks mid-cycle, then advances one edge.
  task automatic cycle();
    #3;
    check_now();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    for (int i = 0; i < 3; i++) cycle();
  endtask

  initial begin
    reset = 1'b1;
    drive(8, 1, 0, 8, 1, 0, 1, 8, 2, 1, 1, 1);
    #7;
    expect_idle("reset");
    check_now();

    // first instruction after release
    #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0);
    expect_idle("post_reset");
    cycle();
    nop();
    expect_sig("first.erw", S_ERW, 1);
    expect_sig("first.ea3", S_EA3, 8);
    expect_sig("first.etn", S_ETN, 1);
    cycle();
    expect_sig("first.mrw", S_MRW, 1);
    expect_sig("first.ma3", S_MA3, 8);
    expect_sig("first.mtn", S_MTN, 0);
    expect_sig("first.erw0", S_ERW, 0);
    cycle();
    expect_sig("first.wrw", S_WRW, 1);
    expect_sig("first.wa3", S_WA3, 8);
    cycle();
    drain();

    // lw $8 ; addu $9,$8 -> one stall
    drive(0, 0, 0, 0, 0, 0, 1, 8, 2, 0, 0, 0);
    expect_sig("lwadd.s0", S_STALL, 0);
    cycle();
    drive(8, 1, 1, 0, 0, 0, 1, 9, 1, 0, 0, 0);
    expect_sig("lwadd.s1", S_STALL, 1);
    expect_sig("lwadd.etn", S_ETN, 2);
    cycle();
    expect_sig("lwadd.s2", S_STALL, 0);
    expect_sig("lwadd.ma3", S_MA3, 8);
    expect_sig("lwadd.mtn", S_MTN, 1);
    expect_sig("lwadd.bub_rw", S_ERW, 0);
    expect_sig("lwadd.bub_a3", S_EA3, 0);
    cycle();
    nop();
    expect_sig("lwadd.ea3", S_EA3, 9);
    expect_sig("lwadd.etn1", S_ETN, 1);
    expect_sig("lwadd.wa3", S_WA3, 8);
    cycle();
    drain();

    // lw $8 ; beq $8,$8 -> two stalls, one combined for rs+rt
    drive(0, 0, 0, 0, 0, 0, 1, 8, 2, 0, 0, 0);
    cycle();
    drive(8, 1, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0);
    expect_sig("lwbeq.s1", S_STALL, 1);
    cycle();
    expect_sig("lwbeq.s2", S_STALL, 1);
    expect_sig("lwbeq.mtn", S_MTN, 1);
    cycle();
    expect_sig("lwbeq.s3", S_STALL, 0);
    expect_sig("lwbeq.wa3", S_WA3, 8);
    cycle();
    drain();

    // addu $9 ; beq $0,$9 -> one stall
    drive(0, 0, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0);
    cycle();
    drive(0, 1, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    expect_sig("addbeq.s1", S_STALL, 1);
    cycle();
    expect_sig("addbeq.s2", S_STALL, 0);
    expect_sig("addbeq.mtn", S_MTN, 0);
    cycle();
    drain();

    // lw $8 ; instruction carrying $8 in rs but not reading it -> no stall
    drive(0, 0, 0, 0, 0, 0, 1, 8, 2, 0, 0, 0);
    cycle();
    drive(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_sig("unused.s", S_STALL, 0);
    cycle();
    drain();

    // writer to $0 then reader of $0 -> no stall
    drive(0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0);
    cycle();
    drive(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    expect_sig("zero.s", S_STALL, 0);
    expect_sig("zero.erw", S_ERW, 0);
    cycle();
    drain();

    // mult ; mflo -> 5 stall cycles
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    expect_sig("mult.busy0", S_BUSY, 0);
    expect_sig("mult.s0", S_STALL, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 10, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      expect_sig("mult.busy", S_BUSY, 1);
      expect_sig("mult.stall", S_STALL, 1);
      cycle();
    end
    expect_sig("mult.busy_end", S_BUSY, 0);
    expect_sig("mult.go", S_STALL, 0);
    cycle();
    nop();
    expect_sig("mult.ea3", S_EA3, 10);
    cycle();
    drain();

    // lw $8 ; div $8,$9 (stalled start must not load) ; mflo -> 10 stall cycles
    drive(0, 0, 0, 0, 0, 0, 1, 8, 2, 0, 0, 0);
    cycle();
    drive(8, 1, 1, 9, 1, 1, 0, 0, 0, 1, 1, 1);
    expect_sig("div.gpr_stall", S_STALL, 1);
    cycle();
    expect_sig("div.no_load", S_BUSY, 0);
    expect_sig("div.accept", S_STALL, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 10, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      expect_sig("div.busy", S_BUSY, 1);
      expect_sig("div.stall", S_STALL, 1);
      cycle();
    end
    expect_sig("div.busy_end", S_BUSY, 0);
    expect_sig("div.go", S_STALL, 0);
    cycle();
    drain();

    // async reset mid-div with counter at 4 and mflo stalled
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 10, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      expect_sig("rst.busy", S_BUSY, 1);
      expect_sig("rst.stall", S_STALL, 1);
      cycle();
    end
    #1;
    expect_sig("rst.pre_busy", S_BUSY, 1);
    expect_sig("rst.pre_stall", S_STALL, 1);
    check_now();
    reset = 1'b1;
    #1;
    expect_sig("rst.async_busy", S_BUSY, 0);
    expect_sig("rst.async_stall", S_STALL, 0);
    expect_sig("rst.async_mrw", S_MRW, 0);
    check_now();
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    expect_sig("rst.after_stall", S_STALL, 0);
    expect_sig("rst.after_busy", S_BUSY, 0);
    expect_sig("rst.after_ea3", S_EA3, 10);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

- Producer-side companion to the E-stage forwarding muxes of the five-stage MIPS pipeline.
- Keeps a shadow pipeline of destination register, write-enable and remaining-latency (Tnew) for the E, M and W stages.
- Compares that state against the D-stage instruction's source needs (Tuse) and raises a stall when forwarding cannot deliver the value in time.
- Also owns the multiply/divide busy counter and stalls any HI/LO instruction while the unit is busy.
- Its registered `E_/M_/W_RegWrite` and `*_RegA3` outputs are the values the forwarding muxes compare against.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports (clock and reset first):
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `D_rs`, `D_rt` input 5 each: D-stage source register numbers.
- `D_use_rs`, `D_use_rt` input 1 each: source actually read.
- `D_Tuse_rs`, `D_Tuse_rt` input 2 each: cycles until the value is consumed (0 = in D, 1 = in E, 2 = in M).
- `D_RegWrite` input 1: D instruction writes GPR.
- `D_RegA3` input 5: its destination register.
- `D_Tnew` input 2: cycles, counted from entry into E, until its result is forwardable (ALU 1, load 2, link 0).
- `D_md_start` input 1: D instruction is mult/multu/div/divu.
- `D_md_div` input 1: start is a divide.
- `D_uses_md` input 1: D instruction is md start, mfhi/mflo or mthi/mtlo.
- `stall` output 1: freeze PC and the D register; insert a bubble into E.
- `E_RegWrite`, `M_RegWrite`, `W_RegWrite` output 1 each: shadow write-enables.
- `E_RegA3`, `M_RegA3`, `W_RegA3` output 5 each: shadow destinations.
- `E_Tnew`, `M_Tnew` output 2 each: remaining latency per stage.
- `md_busy` output 1: busy counter non-zero.

## Operation
- Stage record is {RegWrite, A3, Tnew}. A record with A3 == 0 is forced to RegWrite = 0.
- Each edge when not stalled:
  - E ← D record (Tnew = `D_Tnew`).
  - M ← E record with Tnew = max(E_Tnew − 1, 0).
  - W ← M record; W Tnew is implicitly 0.
- Each edge when stalled:
  - E ← bubble {0, 0, 0}.
  - M and W advance normally, so the pipeline drains.
- GPR hazard, evaluated for each used source s ∈ {rs, rt} and each stage X ∈ {E, M}:
  - Hazard when X_RegWrite && X_RegA3 == s && s != 0 && X_Tnew > Tuse_s.
  - W never causes a stall.
- MD hazard: `D_uses_md && md_busy`.
- Combining: `stall` = any GPR hazard OR MD hazard. It is purely combinational from current state and D inputs.
- MD counter:
  - On a non-stalled edge with `D_md_start`, load `DIV_CYCLES` if `D_md_div`, else `MULT_CYCLES`.
  - Otherwise decrement when non-zero.
  - `md_busy` = counter != 0.
- The block sees no flush input; branch delay slot semantics mean no squash is required.

## Timing
- Reset: all stage records {0, 0, 0}, counter 0. Therefore `stall` = 0, `md_busy` = 0, all RegWrite/A3/Tnew outputs 0.
- `stall` has zero latency. Shadow and counter outputs update one edge after the decision.
- Load followed by a dependent ALU op (Tuse 1):
  - Cycle n: load in E, Tnew 2 → stall.
  - Cycle n+1: load in M, Tnew 1 → no stall; value forwarded from M.
  - Exactly one stall cycle.
- Load followed by a dependent beq (Tuse 0): two stall cycles.
- MD start with `MULT_CYCLES` = 5 accepted at edge k: `md_busy` high for the 5 cycles after edge k. An mflo presented at k+1 stalls for 5 cycles and proceeds on the 6th.
- Simultaneous events:
  - rs and rt hazards in the same cycle give a single stall.
  - A stalled `D_md_start` does not load the counter.
  - A new start during busy is impossible, because it stalls.
- Reset asserted mid-stall or mid-MD clears everything asynchronously. The first cycle after release never stalls.
- Tnew never underflows; it saturates at 0.

## Structure
- Shared package holds:
  - Tuse/Tnew encodings: `TUSE_D`, `TUSE_E`, `TUSE_M`, `TNEW_ALU`, `TNEW_LOAD`.
  - The stage-record struct.
  - `MULT_CYCLES` and `DIV_CYCLES` defaults.
- One sub-module, `md_busy_counter`: load/decrement counter exposing `busy`. Everything else is flat in `hazard_tracker`.

## Test plan
- Reset with garbage inputs, then release → all outputs 0. First D instruction (`D_RegWrite`=1, A3=8, Tnew=1) appears as E_RegA3=8, E_Tnew=1 after one edge.
- lw $8 then addu using $8 (Tuse_rs=1) → `stall`=1 for exactly one cycle. Next cycle M_RegA3=8, M_Tnew=1, `stall`=0, and E holds a bubble during the stall.
- lw $8 then beq reading $8 (Tuse 0) → two stall cycles. addu $9 then beq reading $9 → one stall cycle.
- Writer to $0 with Tnew 2, then a reader of $0 → no stall. E_RegWrite reads 0.
- mult (`MULT_CYCLES`=5) then mflo → `md_busy` high 5 cycles, `stall` high 5 cycles, mflo accepted on the 6th. Same with div → 10 cycles.
- Assert `reset` asynchronously mid-div with counter at 4 and a stall active → `md_busy` and `stall` drop to 0 before the next clock edge.
